// File: rtl/stream_absorb_fifo.sv
// stream_absorb_fifo
// Receive buffer for valid-only (non-stallable) streams. Words are stored in a
// LUT-RAM style FIFO and presented downstream with ready/valid, first-word
// fall-through. sti_afull warns SLACK entries early so an upstream fixed-latency
// pipeline can drain its in-flight words without loss; any word that still
// arrives while full is dropped and recorded in a sticky overflow flag.
module stream_absorb_fifo #(
    parameter int DW    = 32,
    parameter int AW    = 4,
    parameter int SLACK = 3
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          clr,
    input  logic          sti_valid,
    input  logic [DW-1:0] sti_data,
    output logic          sti_afull,
    output logic          sto_valid,
    input  logic          sto_ready,
    output logic [DW-1:0] sto_data,
    output logic [AW:0]   count,
    output logic          overflow
);

    localparam int          DEPTH    = 2**AW;
    localparam logic [AW:0] LP_FULL  = (AW+1)'(DEPTH);
    localparam logic [AW:0] LP_AFULL = (AW+1)'(DEPTH - SLACK);

    logic [DW-1:0] r_mem [0:DEPTH-1];
    logic [AW-1:0] r_wr_ptr;
    logic [AW-1:0] r_rd_ptr;
    logic [AW:0]   r_count;
    logic          r_overflow;

    logic          w_full;
    logic          w_pop;
    logic          w_push;
    logic          w_drop;

    // A pop in the same cycle frees the slot, so a full FIFO still accepts.
    assign w_full = (r_count == LP_FULL);
    assign w_pop  = sto_valid & sto_ready;
    assign w_push = sti_valid & (~w_full | w_pop);
    assign w_drop = sti_valid & w_full & ~w_pop;

    // Storage write; no reset so the array maps onto distributed RAM.
    always_ff @(posedge clk) begin
        if (w_push && !clr)
            r_mem[r_wr_ptr] <= sti_data;
    end

    // Pointers, occupancy and sticky overflow; clr wins over push/pop.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_count    <= '0;
            r_overflow <= 1'b0;
        end else if (clr) begin
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_count    <= '0;
            r_overflow <= 1'b0;
        end else begin
            if (w_push)
                r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_pop)
                r_rd_ptr <= r_rd_ptr + 1'b1;
            r_count <= r_count + {{AW{1'b0}}, w_push} - {{AW{1'b0}}, w_pop};
            if (w_drop)
                r_overflow <= 1'b1;
        end
    end

    // Outputs decode registered state only, so reset clears them at once and
    // there is no combinational path from sti_* to sto_*.
    assign sto_valid = (r_count != '0);
    assign sto_data  = sto_valid ? r_mem[r_rd_ptr] : '0;
    assign sti_afull = (r_count >= LP_AFULL);
    assign count     = r_count;
    assign overflow  = r_overflow;

endmodule

// File: tb/tb_stream_absorb_fifo.sv
// Directed bench for stream_absorb_fifo (DW=32, AW=4, SLACK=3).
// Inputs change 1 ns after a rising edge; outputs are sampled there too.
module tb_stream_absorb_fifo;

    logic        clk = 1'b0;
    logic        rst;
    logic        clr;
    logic        sti_valid;
    logic [31:0] sti_data;
    logic        sti_afull;
    logic        sto_valid;
    logic        sto_ready;
    logic [31:0] sto_data;
    logic [4:0]  count;
    logic        overflow;

    int n_chk  = 0;
    int n_fail = 0;

    stream_absorb_fifo #(.DW(32), .AW(4), .SLACK(3)) dut (
        .clk       (clk),
        .rst       (rst),
        .clr       (clr),
        .sti_valid (sti_valid),
        .sti_data  (sti_data),
        .sti_afull (sti_afull),
        .sto_valid (sto_valid),
        .sto_ready (sto_ready),
        .sto_data  (sto_data),
        .count     (count),
        .overflow  (overflow)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst = 1'b1; clr = 1'b0; sti_valid = 1'b0; sti_data = '0; sto_ready = 1'b0;
        tick(); tick();
        chk("rst_count", 32'(count), 0);
        rst = 1'b0;
        repeat (5) tick();
        chk("idle_valid", 32'(sto_valid), 0);
        chk("idle_data",  sto_data, 0);
        chk("idle_count", 32'(count), 0);
        chk("idle_afull", 32'(sti_afull), 0);
        chk("idle_ovf",   32'(overflow), 0);

        // single word, held 4 cycles, then accepted
        sti_valid = 1'b1; sti_data = 32'hA5A5_0001;
        tick();
        sti_valid = 1'b0; sti_data = '0;
        for (int i = 0; i < 4; i++) begin
            chk("single_valid", 32'(sto_valid), 1);
            chk("single_data",  sto_data, 32'hA5A5_0001);
            chk("single_count", 32'(count), 1);
            tick();
        end
        sto_ready = 1'b1;
        tick();
        sto_ready = 1'b0;
        chk("single_pop_valid", 32'(sto_valid), 0);
        chk("single_pop_count", 32'(count), 0);

        // fill 0..15; afull must rise exactly at count 13
        for (int i = 0; i < 16; i++) begin
            sti_valid = 1'b1; sti_data = 32'(i);
            tick();
            chk("fill_count", 32'(count), 32'(i + 1));
            chk("fill_afull", 32'(sti_afull), (i + 1 >= 13) ? 1 : 0);
        end
        sti_valid = 1'b0;
        chk("full_ovf", 32'(overflow), 0);
        chk("full_head", sto_data, 0);

        // overflow: push while full, no pop
        sti_valid = 1'b1; sti_data = 32'hDEAD;
        tick();
        sti_valid = 1'b0;
        chk("ovf_flag",  32'(overflow), 1);
        chk("ovf_count", 32'(count), 16);
        sto_ready = 1'b1;
        for (int i = 0; i < 16; i++) begin
            chk("drain_data",  sto_data, 32'(i));
            chk("drain_valid", 32'(sto_valid), 1);
            tick();
        end
        sto_ready = 1'b0;
        chk("drain_empty", 32'(count), 0);
        chk("drain_nodead_valid", 32'(sto_valid), 0);
        chk("ovf_sticky", 32'(overflow), 1);
        clr = 1'b1;
        tick();
        clr = 1'b0;
        chk("clr_ovf",   32'(overflow), 0);
        chk("clr_count", 32'(count), 0);

        // full with concurrent push/pop
        for (int i = 0; i < 16; i++) begin
            sti_valid = 1'b1; sti_data = 32'(i);
            tick();
        end
        chk("refill_count", 32'(count), 16);
        sti_valid = 1'b1; sti_data = 32'h100; sto_ready = 1'b1;
        chk("pp_head", sto_data, 0);
        tick();
        sti_valid = 1'b0;
        chk("pp_count", 32'(count), 16);
        chk("pp_ovf",   32'(overflow), 0);
        for (int i = 1; i < 17; i++) begin
            chk("pp_drain", sto_data, (i == 16) ? 32'h100 : 32'(i));
            tick();
        end
        sto_ready = 1'b0;
        chk("pp_empty", 32'(count), 0);

        // continuous stream: each word visible the cycle after its push
        sto_ready = 1'b1;
        for (int i = 0; i < 40; i++) begin
            sti_valid = 1'b1; sti_data = 32'h200 + 32'(i);
            tick();
            chk("strm_valid", 32'(sto_valid), 1);
            chk("strm_data",  sto_data, 32'h200 + 32'(i));
            chk("strm_count", 32'(count), 1);
        end
        // async reset between edges
        #2 rst = 1'b1;
        #1;
        chk("arst_valid", 32'(sto_valid), 0);
        chk("arst_count", 32'(count), 0);
        chk("arst_data",  sto_data, 0);
        sti_valid = 1'b0; sto_ready = 1'b0;
        tick();
        rst = 1'b0;
        tick();
        chk("post_rst_count", 32'(count), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
